// File: rtl/fir_avg_pkg.sv
// Shared defaults and elaboration helpers for the power-of-two moving-average FIR.
package fir_avg_pkg;

   localparam int unsigned W_DEF    = 16;
   localparam int unsigned TAPS_DEF = 4;

   // Shift amount that turns the window sum into the average; valid for powers of two only.
   function automatic int unsigned taps_to_l(input int unsigned taps);
      return $clog2(taps);
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/fir_avg_delay_line.sv
// Circular sample buffer: writes at the pointer and exposes the slot about to be evicted.
module fir_avg_delay_line
   import fir_avg_pkg::*;
#(
   parameter  int unsigned W    = W_DEF,
   parameter  int unsigned TAPS = TAPS_DEF,
   localparam int unsigned L    = taps_to_l(TAPS)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         clear,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] oldest
);

   logic [W-1:0] mem_q [TAPS];
   logic [L-1:0] ptr_q;

   // The slot under the write pointer holds the sample leaving the window on the next push.
   assign oldest = mem_q[ptr_q];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
         for (int unsigned i = 0; i < TAPS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clear) begin
         ptr_q <= '0;
         for (int unsigned i = 0; i < TAPS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[ptr_q] <= wr_data;
         ptr_q        <= ptr_q + L'(1);
      end
   end

endmodule

// File: rtl/fir_avg_stream.sv
// Streaming moving-average filter: running window sum over the last TAPS accepted samples,
// with the average obtained by a truncating shift.
module fir_avg_stream
   import fir_avg_pkg::*;
#(
   parameter  int unsigned W    = W_DEF,
   parameter  int unsigned TAPS = TAPS_DEF,
   localparam int unsigned L    = taps_to_l(TAPS),
   localparam int unsigned SumW = W + L
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   input  logic [W-1:0]    in_data,
   input  logic            clear,
   output logic            out_valid,
   output logic [SumW-1:0] out_sum,
   output logic [W-1:0]    out_avg,
   output logic            primed
);

   if (!is_pow2(TAPS) || (TAPS < 2) || (TAPS > 64)) begin : g_bad_taps
      $error("fir_avg_stream: TAPS=%0d must be a power of two in 2..64", TAPS);
   end

   if ((W < 2) || (W > 32)) begin : g_bad_width
      $error("fir_avg_stream: W=%0d must be in 2..32", W);
   end

   localparam logic [L:0] FillMax = (L + 1)'(TAPS);

   logic            accept;
   logic [W-1:0]    oldest;
   logic [SumW-1:0] acc_q, acc_d;
   logic [L:0]      fill_q, fill_d;
   logic            primed_q, primed_d;
   logic            out_valid_q;
   logic [W-1:0]    avg_q;

   // Clear wins over a simultaneous sample, which is dropped.
   assign accept = in_valid & ~clear;

   fir_avg_delay_line #(
      .W    (W),
      .TAPS (TAPS)
   ) u_delay_line (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (accept),
      .clear   (clear),
      .wr_data (in_data),
      .oldest  (oldest)
   );

   // acc always contains the evicted sample, so the subtraction never underflows.
   always_comb begin
      acc_d    = acc_q + SumW'(in_data) - SumW'(oldest);
      fill_d   = (fill_q == FillMax) ? fill_q : fill_q + (L + 1)'(1);
      primed_d = (fill_d == FillMax);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q       <= '0;
         fill_q      <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         avg_q       <= '0;
      end else if (clear) begin
         acc_q       <= '0;
         fill_q      <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         avg_q       <= '0;
      end else if (accept) begin
         acc_q       <= acc_d;
         fill_q      <= fill_d;
         primed_q    <= primed_d;
         out_valid_q <= 1'b1;
         avg_q       <= acc_d[SumW-1:L];
      end else begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_sum   = acc_q;
   assign out_avg   = avg_q;
   assign primed    = primed_q;
   assign out_valid = out_valid_q;

   a_valid_follows_accept : assert property (
      @(posedge clk) disable iff (!reset_n) accept |=> out_valid);

   a_no_valid_without_accept : assert property (
      @(posedge clk) disable iff (!reset_n) !accept |=> !out_valid);

   a_hold_through_gap : assert property (
      @(posedge clk) disable iff (!reset_n)
      (!in_valid && !clear) |=> ($stable(out_sum) && $stable(out_avg) && $stable(primed)));

   a_primed_means_full : assert property (
      @(posedge clk) disable iff (!reset_n) primed |-> (fill_q == FillMax));

endmodule

// File: doc/fir_avg_stream.md
FIR_AVG_STREAM -- requirements
Module: fir_avg_stream

Interface
REQ-001 SHALL have parameter W, default 16, meaning input sample width in bits (2..32).
REQ-002 SHALL have parameter TAPS, default 4, meaning window depth; it must be a power of two (2..64), with L = log2(TAPS).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data is accepted this cycle.
REQ-006 SHALL have port in_data, input, W, meaning an unsigned sample.
REQ-007 SHALL have port clear, input, 1, meaning a synchronous flush of all history.
REQ-008 SHALL have port out_valid, output, 1, meaning out_sum, out_avg and primed are updated this cycle.
REQ-009 SHALL have port out_sum, output, W+L, meaning the unsigned sum of the last TAPS accepted samples.
REQ-010 SHALL have port out_avg, output, W, meaning out_sum >> L (truncating).
REQ-011 SHALL have port primed, output, 1, meaning at least TAPS samples have been accepted since the last reset or clear.

Function
REQ-012 SHALL hold TAPS samples in a circular buffer with write pointer wr_ptr (L bits, wrapping TAPS-1 -> 0).
REQ-013 SHALL, on a cycle with in_valid=1 and clear=0, write in_data at wr_ptr, advance wr_ptr, and update acc <= acc + in_data - buf[wr_ptr] (the evicted oldest sample).
REQ-014 SHALL use a running-sum accumulator of W+L bits; no intermediate value overflows (sum <= TAPS*(2^W-1)) and no saturation logic is needed.
REQ-015 SHALL register outputs: out_sum, out_avg and out_valid reflect the cycle-N acceptance at cycle N+1 (latency 1).
REQ-016 SHALL pulse out_valid for exactly one cycle per accepted sample, and keep it low on cycles without acceptance.
REQ-017 SHALL hold out_sum, out_avg and primed unchanged while in_valid=0; gaps of any length have no effect on the window.
REQ-018 SHALL treat unfilled buffer slots as zero, so the first TAPS outputs are partial sums.
REQ-019 SHALL keep a fill counter saturating at TAPS, and drive primed high from the output cycle of the TAPS-th accepted sample onward.
REQ-020 SHALL, on clear=1, zero all buffer slots, acc, wr_ptr, the fill counter, out_sum, out_avg and primed on the next edge, and drive out_valid=0 there; clear overrides a simultaneous in_valid, and that sample is dropped.
REQ-021 SHALL accept back-to-back samples every cycle (no back-pressure).

Reset
REQ-022 SHALL, while reset_n=0, asynchronously force all buffer slots, acc, wr_ptr, the fill counter, out_sum, out_avg, out_valid and primed to 0.
REQ-023 SHALL deassert reset synchronously to clk (the integrator supplies a synchronised reset_n); the first sample may be accepted on the first edge after deassertion.
REQ-024 SHALL, on reset assertion mid-stream, discard all history; post-reset behaviour is identical to power-up.

Structure
REQ-025 SHALL place parameter defaults (W_DEF=16, TAPS_DEF=4) and the rule that derives L from TAPS in a shared package fir_avg_pkg.
REQ-026 SHALL implement the circular buffer (storage, wr_ptr, read of the oldest slot) as sub-module fir_avg_delay_line; the accumulator, fill counter and output registers stay in fir_avg_stream.
REQ-027 SHALL contain an elaboration-time check that rejects a TAPS value that is not a power of two.

Verification (W=16, TAPS=4)
REQ-028 Reset: hold reset_n=0 with in_valid toggling -> all outputs 0; release -> outputs remain 0 until the first acceptance.
REQ-029 Ramp: in_data 1,2,3,4,5 on consecutive cycles -> out_sum 1,3,6,10,14; out_avg 0,0,1,2,3; primed first high with 10.
REQ-030 Max: 0xFFFF for 5 cycles -> out_sum 0x3FFFC from the 4th output onward, out_avg 0xFFFF, no wrap.
REQ-031 Gaps: 1,_,_,2,_,3,4,8 (_ = in_valid low) -> out_sum 1,3,6,10,17; out_valid only on the 5 acceptance cycles; outputs hold through gaps.
REQ-032 Clear: after 4 samples of 7, assert clear together with in_valid(data 9) -> next cycle out_sum=0, primed=0, out_valid=0; then sample 5 -> out_sum 5.
REQ-033 Async reset: drop reset_n mid-cycle during streaming -> outputs 0 before the next clk edge; restart with 2,2 -> out_sum 2,4.
